adder3_sched: RTL
=================

# adder3_sched

Scheduler that shares the dual-mode modular adder (12-bit Kyber add/sub mode, 24-bit Dilithium add mode) between a Kyber NTT requester (K) and a Dilithium NTT requester (D). It arbitrates burst requests, drives the adder's mode and delay-line selects for the whole burst, and issues one beat strobe per coefficient pair. It tracks in-flight beats through the adder's fixed operand delay lines and flags each result with its owner and index. It drains the pipeline before handing the adder to the other requester.

## Interface
- LAT_K, 7, cycles from a K issue to its result (b-operand delay line depth)
- LAT_D, 6, cycles from a D issue to its result (a-operand delay line depth)
- IDXW, 8, beat index width; max burst = 2^IDXW
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- req_k / req_d  in  1  burst request, level; held until the matching gnt pulse
- len_k / len_d  in  IDXW+1  burst length 0..2^IDXW, sampled in the grant cycle
- stall  in  1  suppresses beat issue this cycle; in-flight beats keep moving
- gnt_k / gnt_d  out  1  one-cycle grant pulse
- adder_mode  out  1  0 = Kyber 12-bit, 1 = Dilithium 24-bit
- sel_a  out  1  1 during K ownership (b taken from delay line)
- sel_d2ntt  out  1  1 during D ownership (a taken from delay line)
- issue  out  1  beat strobe: operands for issue_idx are presented this cycle
- issue_idx  out  IDXW  beat index of current issue
- res_valid  out  1  adder output is a valid result this cycle
- res_owner  out  1  0 = K, 1 = D; valid with res_valid
- res_idx  out  IDXW  beat index of the result
- done_k / done_d  out  1  one-cycle pulse coinciding with the last res_valid of a burst
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, BURST, DRAIN.
- In IDLE, a single pending request is granted.
- When both are pending in IDLE, grant goes to the requester not granted last. The last-owner register resets to D, so K wins the first tie.
- Grant edge: gnt_x pulses, adder_mode/sel_a/sel_d2ntt take the owner's values, len is latched, and the state becomes BURST.
  - K: mode 0, sel_a 1, sel_d2ntt 0.
  - D: mode 1, sel_a 0, sel_d2ntt 1.
- BURST: issue = ~stall while beats remain; issue_idx counts 0..len-1 and advances only on issue. After the last issue, go to DRAIN.
- DRAIN: no issue. Wait until the last beat's result emerges. done_x pulses with that res_valid, then return to IDLE.
- len = 0: grant and select update occur, no issue. done_x pulses one cycle after gnt, then IDLE.
- Tag pipeline: a shift register of {valid, idx} with depth max(LAT_K, LAT_D), tapped at the owner's latency. It is fixed for the burst because selects do not change until IDLE.
- adder_mode/sel_a/sel_d2ntt hold their value through DRAIN and in IDLE, until the next grant.
- No request is granted while busy. A request raised mid-burst waits.

## Timing
- Reset values: all outputs 0, state IDLE, tag pipeline cleared.
- A request visible in IDLE at cycle T-1 produces gnt and new selects in cycle T. The first possible issue is T+1, giving the delay lines one cycle with the new select.
- A beat issued in cycle t has res_valid in cycle t+LAT_K (K) or t+LAT_D (D). Stall bubbles propagate as res_valid = 0.
- done_x is high in the cycle of the final res_valid. The state is IDLE the next cycle. The earliest next gnt is the cycle after that.
- Back-to-back owner switch therefore has a dead gap of LAT_x + 2 cycles after the last issue. This guarantees no stale delay-line data is attributed to the new owner.
- Reset mid-burst: the next edge clears everything. In-flight tags are discarded, with no res_valid or done. Held requests are re-arbitrated from IDLE, with K winning a tie.
- Simultaneous request arrival at the return to IDLE: the tie rule applies. A requester that just finished loses to a pending other.

## Test plan
- Single K burst, len=4, no stall → gnt_k at T; issue T+1..T+4 with idx 0..3; res_valid T+8..T+11; done_k at T+11; mode=0, sel_a=1 throughout.
- Single D burst, len=3, stall high at T+2 → issue at T+1, T+3, T+4 (idx 0,1,2); res_valid at T+7, T+9, T+10; done_d at T+10; mode=1, sel_d2ntt=1.
- req_k and req_d asserted together from reset, len=2 each → K granted first. gnt_d is no earlier than done_k+2. Owners alternate on repeated ties.
- len_k=0 → gnt_k at T, no issue, done_k at T+1, busy low at T+2.
- rst asserted at K burst beat 2 of 8 → next cycle all outputs 0; no res_valid for any in-flight beat; held req_d granted at the first IDLE cycle after reset releases.
- Full burst, len=256, K → idx wraps 255 → done_k after 256 res_valid pulses, with no duplicate or missing indices.

Source files
------------

// File: rtl/adder3_sched.sv
// Arbitrates the shared dual-mode modular adder between the Kyber (K) and Dilithium (D) NTT
// requesters, issues beats and tags results as they leave the adder's operand delay lines.
module adder3_sched #(
  parameter int unsigned LatK = 7,
  parameter int unsigned LatD = 6,
  parameter int unsigned IdxW = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_k_i,
  input  logic            req_d_i,
  input  logic [IdxW:0]   len_k_i,
  input  logic [IdxW:0]   len_d_i,
  input  logic            stall_i,
  output logic            gnt_k_o,
  output logic            gnt_d_o,
  output logic            adder_mode_o,
  output logic            sel_a_o,
  output logic            sel_d2ntt_o,
  output logic            issue_o,
  output logic [IdxW-1:0] issue_idx_o,
  output logic            res_valid_o,
  output logic            res_owner_o,
  output logic [IdxW-1:0] res_idx_o,
  output logic            done_k_o,
  output logic            done_d_o,
  output logic            busy_o
);

  localparam int unsigned Depth = (LatK > LatD) ? LatK : LatD;
  localparam logic [IdxW:0] One = (IdxW+1)'(1);

  typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

  state_e                     state_q;
  logic                       gnt_k_q, gnt_d_q;
  logic                       mode_q, sel_a_q, sel_d_q;
  logic                       last_d_q;
  logic [IdxW:0]              len_q, cnt_q;
  logic [Depth-1:0]           tag_v_q;
  logic [Depth-1:0][IdxW-1:0] tag_idx_q;

  logic            issue, last_beat, tap_v, res_valid, done, pick_d;
  logic [IdxW-1:0] tap_idx;

  always_comb begin
    // The grant cycle is left free so the delay lines settle on the new selects.
    issue     = (state_q == StBurst) && !gnt_k_q && !gnt_d_q && (cnt_q < len_q) && !stall_i;
    last_beat = issue && ((cnt_q + One) == len_q);
    tap_v     = mode_q ? tag_v_q[LatD-1] : tag_v_q[LatK-1];
    tap_idx   = mode_q ? tag_idx_q[LatD-1] : tag_idx_q[LatK-1];
    res_valid = tap_v && (state_q != StIdle);
    done      = (state_q == StDrain) &&
                ((len_q == '0) || (res_valid && ({1'b0, tap_idx} == (len_q - One))));
    pick_d    = req_d_i && (!req_k_i || !last_d_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      gnt_k_q   <= 1'b0;
      gnt_d_q   <= 1'b0;
      mode_q    <= 1'b0;
      sel_a_q   <= 1'b0;
      sel_d_q   <= 1'b0;
      last_d_q  <= 1'b1;
      len_q     <= '0;
      cnt_q     <= '0;
      tag_v_q   <= '0;
      tag_idx_q <= '0;
    end else begin
      gnt_k_q   <= 1'b0;
      gnt_d_q   <= 1'b0;
      tag_v_q   <= {tag_v_q[Depth-2:0], issue};
      tag_idx_q <= {tag_idx_q[Depth-2:0], cnt_q[IdxW-1:0]};
      unique case (state_q)
        StIdle: begin
          if (req_k_i || req_d_i) begin
            gnt_k_q  <= !pick_d;
            gnt_d_q  <= pick_d;
            mode_q   <= pick_d;
            sel_a_q  <= !pick_d;
            sel_d_q  <= pick_d;
            last_d_q <= pick_d;
            len_q    <= pick_d ? len_d_i : len_k_i;
            cnt_q    <= '0;
            state_q  <= StBurst;
          end
        end
        StBurst: begin
          if (issue) cnt_q <= cnt_q + One;
          if ((len_q == '0) || last_beat) state_q <= StDrain;
        end
        StDrain: begin
          if (done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt_k_o      = gnt_k_q;
  assign gnt_d_o      = gnt_d_q;
  assign adder_mode_o = mode_q;
  assign sel_a_o      = sel_a_q;
  assign sel_d2ntt_o  = sel_d_q;
  assign issue_o      = issue;
  assign issue_idx_o  = cnt_q[IdxW-1:0];
  assign res_valid_o  = res_valid;
  assign res_owner_o  = mode_q;
  assign res_idx_o    = tap_idx;
  assign done_k_o     = done && !mode_q;
  assign done_d_o     = done && mode_q;
  assign busy_o       = (state_q != StIdle);

endmodule
